// File: rtl/per_error_pkg.sv
// Shared constants and log record type for the peripheral error responder.
package per_error_pkg;

   localparam logic [31:0] PER_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
   localparam int          PER_ERR_MAX_LATENCY  = 8;
   // Widest bus ID the log record can hold; narrower IDs are zero-extended.
   localparam int          PER_ERR_ID_MAX_WIDTH = 16;

   typedef struct packed {
      logic [31:0]                     addr;
      logic                            wen;
      logic [PER_ERR_ID_MAX_WIDTH-1:0] id;
   } per_err_log_t;

endpackage

// File: rtl/xbar_periph_bus.sv
// Peripheral interconnect port bundle: request/grant plus an unstalled response channel.
interface XBAR_PERIPH_BUS #(
   parameter int ID_WIDTH = 5
);
   logic                req;
   logic [31:0]         add;
   logic                wen;
   logic [31:0]         wdata;
   logic [3:0]          be;
   logic [ID_WIDTH-1:0] id;
   logic                gnt;
   logic                r_valid;
   logic                r_opc;
   logic [ID_WIDTH-1:0] r_id;
   logic [31:0]         r_rdata;

   // Handshake: a request is accepted on any rising edge where req && gnt;
   // the response side has no ready, so r_valid is a single-cycle strobe.
   modport Master (output req, add, wen, wdata, be, id,
                   input  gnt, r_valid, r_opc, r_id, r_rdata);
   modport Slave  (input  req, add, wen, wdata, be, id,
                   output gnt, r_valid, r_opc, r_id, r_rdata);
endinterface

// File: rtl/per_error_delay_line.sv
// Generic {valid, data} shift register, DEPTH stages, asynchronous active-low reset.
module per_error_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH-1:0][WIDTH-1:0] r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/per_error_slave.sv
// Error responder for unpopulated peripheral space; grants everything, answers with r_opc=1.
// Optional first-error log/counter/irq enabled by defining PER_ERROR_SLAVE_LOG_EN.
module per_error_slave
   import per_error_pkg::*;
#(
   parameter int          ID_WIDTH     = 5,
   parameter int          RESP_LATENCY = 1,
   parameter logic [31:0] ERR_DATA     = PER_ERR_DATA_DEFAULT,
   parameter int          CNT_WIDTH    = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   XBAR_PERIPH_BUS.Slave        periph_slave,
   input  logic                 i_log_clear,
   output logic                 o_err_irq,
   output logic [31:0]          o_err_addr,
   output logic                 o_err_wen,
   output logic [ID_WIDTH-1:0]  o_err_id,
   output logic [CNT_WIDTH-1:0] o_err_cnt
);

   if (RESP_LATENCY < 1 || RESP_LATENCY > PER_ERR_MAX_LATENCY) begin : g_bad_latency
      $error("per_error_slave: RESP_LATENCY out of range");
   end
   if (ID_WIDTH < 1 || ID_WIDTH > PER_ERR_ID_MAX_WIDTH) begin : g_bad_id_width
      $error("per_error_slave: ID_WIDTH out of range");
   end

   logic w_accept;
   assign w_accept = periph_slave.req;

   assign periph_slave.gnt     = periph_slave.req;
   assign periph_slave.r_opc   = 1'b1;
   assign periph_slave.r_rdata = ERR_DATA;

   per_error_delay_line #(
      .DEPTH (RESP_LATENCY),
      .WIDTH (ID_WIDTH)
   ) u_resp_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (periph_slave.req),
      .i_data  (periph_slave.id),
      .o_valid (periph_slave.r_valid),
      .o_data  (periph_slave.r_id)
   );

`ifdef PER_ERROR_SLAVE_LOG_EN
   per_err_log_t         r_log;
   logic                 r_log_valid;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 w_log_valid_base;
   logic [CNT_WIDTH-1:0] w_cnt_base;

   // Clear wipes the old state first, so a same-cycle access lands on a fresh log.
   assign w_log_valid_base = i_log_clear ? 1'b0 : r_log_valid;
   assign w_cnt_base       = i_log_clear ? '0   : r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_log       <= '0;
         r_log_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_log_valid <= w_log_valid_base | w_accept;
         r_cnt       <= w_cnt_base;
         if (w_accept && !w_log_valid_base) begin
            r_log.addr <= periph_slave.add;
            r_log.wen  <= periph_slave.wen;
            r_log.id   <= PER_ERR_ID_MAX_WIDTH'(periph_slave.id);
         end
         if (w_accept && (w_cnt_base != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= w_cnt_base + CNT_WIDTH'(1);
         end
      end
   end

   assign o_err_irq  = r_log_valid;
   assign o_err_addr = r_log.addr;
   assign o_err_wen  = r_log.wen;
   assign o_err_id   = r_log.id[ID_WIDTH-1:0];
   assign o_err_cnt  = r_cnt;

   logic w_unused;
   assign w_unused = ^{periph_slave.wdata, periph_slave.be, r_log.id};
`else
   assign o_err_irq  = 1'b0;
   assign o_err_addr = '0;
   assign o_err_wen  = 1'b0;
   assign o_err_id   = '0;
   assign o_err_cnt  = '0;

   logic w_unused;
   assign w_unused = ^{periph_slave.wdata, periph_slave.be, periph_slave.add,
                       periph_slave.wen, w_accept, i_log_clear};
`endif

endmodule

// File: tb/tb_per_error_slave.sv
// Bench for per_error_slave: two instances (latency 1 / 16-bit counter, latency 4 / 4-bit counter)
// share one stimulus stream and are checked against an edge-history reference model.
module tb_per_error_slave;

   localparam int IDW   = 5;
   localparam int LAT_A = 1;
   localparam int LAT_B = 4;
   localparam int MAX_A = 65535;
   localparam int MAX_B = 15;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_log_clear = 1'b0;
   logic req = 1'b0;
   logic [31:0] add = '0;
   logic wen = 1'b0;
   logic [IDW-1:0] id = '0;
   logic [31:0] wdata = '0;
   logic [3:0] be = '0;

   logic            irq_a, irq_b, ewen_a, ewen_b;
   logic [31:0]     eaddr_a, eaddr_b;
   logic [IDW-1:0]  eid_a, eid_b;
   logic [15:0]     cnt_a;
   logic [3:0]      cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   // clock / reset
   always #5 i_clk = ~i_clk;

   XBAR_PERIPH_BUS #(.ID_WIDTH(IDW)) bus_a ();
   XBAR_PERIPH_BUS #(.ID_WIDTH(IDW)) bus_b ();

   assign bus_a.req = req;   assign bus_b.req = req;
   assign bus_a.add = add;   assign bus_b.add = add;
   assign bus_a.wen = wen;   assign bus_b.wen = wen;
   assign bus_a.id  = id;    assign bus_b.id  = id;
   assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;
   assign bus_a.be  = be;    assign bus_b.be  = be;

   per_error_slave #(.ID_WIDTH(IDW), .RESP_LATENCY(LAT_A), .CNT_WIDTH(16)) dut_a (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .periph_slave(bus_a), .i_log_clear(i_log_clear),
      .o_err_irq(irq_a), .o_err_addr(eaddr_a), .o_err_wen(ewen_a), .o_err_id(eid_a),
      .o_err_cnt(cnt_a));

   per_error_slave #(.ID_WIDTH(IDW), .RESP_LATENCY(LAT_B), .CNT_WIDTH(4)) dut_b (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .periph_slave(bus_b), .i_log_clear(i_log_clear),
      .o_err_irq(irq_b), .o_err_addr(eaddr_b), .o_err_wen(ewen_b), .o_err_id(eid_b),
      .o_err_cnt(cnt_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: history of {req,id} per edge since reset, plus log state
   logic            hist_req[$];
   logic [IDW-1:0]  hist_id[$];
   logic            m_log_valid;
   logic [31:0]     m_addr;
   logic            m_wen;
   logic [IDW-1:0]  m_id;
   int              m_cnt_a, m_cnt_b;

   always @(posedge i_clk) begin
      if (!i_rst_n) begin
         hist_req.delete();
         hist_id.delete();
         m_log_valid = 1'b0;
         m_addr = '0; m_wen = 1'b0; m_id = '0;
         m_cnt_a = 0; m_cnt_b = 0;
      end else begin
         hist_req.push_back(req);
         hist_id.push_back(id);
         if (hist_req.size() > 8) begin
            void'(hist_req.pop_front());
            void'(hist_id.pop_front());
         end
         if (i_log_clear) begin
            m_log_valid = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
         end
         if (req) begin
            if (!m_log_valid) begin
               m_addr = add; m_wen = wen; m_id = id;
               m_log_valid = 1'b1;
            end
            m_cnt_a = (m_cnt_a < MAX_A) ? m_cnt_a + 1 : MAX_A;
            m_cnt_b = (m_cnt_b < MAX_B) ? m_cnt_b + 1 : MAX_B;
         end
      end
   end

   // Response visible after edge e belongs to the access sampled at edge e-L+1.
   function automatic logic exp_v(input int lat);
      return (hist_req.size() >= lat) ? hist_req[hist_req.size() - lat] : 1'b0;
   endfunction

   function automatic logic [IDW-1:0] exp_id(input int lat);
      return (hist_id.size() >= lat) ? hist_id[hist_id.size() - lat] : '0;
   endfunction

   // scoreboard compare on the falling edge
   always @(negedge i_clk) begin
      logic        e_irq, e_wen;
      logic [31:0] e_addr;
      logic [IDW-1:0] e_id;
      int          e_ca, e_cb;
      chk("gnt_a", bus_a.gnt, req);
      chk("gnt_b", bus_b.gnt, req);
      chk("r_opc_a", bus_a.r_opc, 1);
      chk("r_opc_b", bus_b.r_opc, 1);
      chk("r_rdata_a", bus_a.r_rdata, 32'hDEAD_BEEF);
      chk("r_rdata_b", bus_b.r_rdata, 32'hDEAD_BEEF);
      if (!i_rst_n) begin
         chk("rst_r_valid_a", bus_a.r_valid, 0);
         chk("rst_r_valid_b", bus_b.r_valid, 0);
         chk("rst_r_id_a", bus_a.r_id, 0);
         chk("rst_r_id_b", bus_b.r_id, 0);
         e_irq = 0; e_wen = 0; e_addr = 0; e_id = 0; e_ca = 0; e_cb = 0;
      end else begin
         chk("r_valid_a", bus_a.r_valid, exp_v(LAT_A));
         chk("r_valid_b", bus_b.r_valid, exp_v(LAT_B));
         chk("r_id_a", bus_a.r_id, exp_id(LAT_A));
         chk("r_id_b", bus_b.r_id, exp_id(LAT_B));
`ifdef PER_ERROR_SLAVE_LOG_EN
         e_irq = m_log_valid; e_wen = m_wen; e_addr = m_addr; e_id = m_id;
         e_ca = m_cnt_a; e_cb = m_cnt_b;
`else
         e_irq = 0; e_wen = 0; e_addr = 0; e_id = 0; e_ca = 0; e_cb = 0;
`endif
      end
      chk("irq_a", irq_a, e_irq);     chk("irq_b", irq_b, e_irq);
      chk("addr_a", eaddr_a, e_addr); chk("addr_b", eaddr_b, e_addr);
      chk("ewen_a", ewen_a, e_wen);   chk("ewen_b", ewen_b, e_wen);
      chk("eid_a", eid_a, e_id);      chk("eid_b", eid_b, e_id);
      chk("cnt_a", cnt_a, e_ca);      chk("cnt_b", cnt_b, e_cb);
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [IDW-1:0] i);
      req = r; add = a; wen = w; id = i;
      wdata = $urandom; be = 4'($urandom_range(0, 15));
   endtask

   logic           obs_va[11], obs_vb[11];
   logic [IDW-1:0] obs_ida[11], obs_idb[11];

   initial begin
      drive(0, 0, 0, 0);
      tick(); tick();
      chk("lit_reset_r_valid_a", bus_a.r_valid, 0);
      chk("lit_reset_irq_b", irq_b, 0);
      chk("lit_reset_cnt_b", cnt_b, 0);
      i_rst_n = 1'b1;
      tick();

      // single read, latency 1
      drive(1, 32'h1A10_0040, 1, 3);
      #1;
      chk("lit_gnt_same_cycle", bus_a.gnt, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("lit_single_r_valid", bus_a.r_valid, 1);
      chk("lit_single_r_id", bus_a.r_id, 3);
      chk("lit_single_r_opc", bus_a.r_opc, 1);
      chk("lit_single_r_rdata", bus_a.r_rdata, 32'hDEAD_BEEF);
      tick(); tick(); tick(); tick();

      // 6-cycle burst, ids 0..5
      for (int i = 0; i < 11; i++) begin
         if (i < 6) drive(1, 32'h2000_0000 + 32'(i * 4), 1, IDW'(i));
         else       drive(0, 0, 0, IDW'(i));
         tick();
         obs_va[i] = bus_a.r_valid; obs_ida[i] = bus_a.r_id;
         obs_vb[i] = bus_b.r_valid; obs_idb[i] = bus_b.r_id;
      end
      drive(0, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         chk("lit_burst_vb", obs_vb[i], (i >= 3 && i <= 8));
         if (i >= 3 && i <= 8) chk("lit_burst_idb", obs_idb[i], i - 3);
         chk("lit_burst_va", obs_va[i], (i <= 5));
         if (i <= 5) chk("lit_burst_ida", obs_ida[i], i);
      end

      // log: clear, then write id 7 and read id 2
      i_log_clear = 1'b1; tick(); i_log_clear = 1'b0;
      drive(1, 32'h1A20_0000, 0, 7); tick();
      drive(1, 32'h1A30_0000, 1, 2); tick();
      drive(0, 0, 0, 0);
`ifdef PER_ERROR_SLAVE_LOG_EN
      chk("lit_log_addr", eaddr_a, 32'h1A20_0000);
      chk("lit_log_wen", ewen_a, 0);
      chk("lit_log_id", eid_a, 7);
      chk("lit_log_cnt_a", cnt_a, 2);
      chk("lit_log_cnt_b", cnt_b, 2);
      chk("lit_log_irq", irq_a, 1);
`else
      chk("lit_nolog_addr", eaddr_a, 0);
      chk("lit_nolog_cnt", cnt_a, 0);
      chk("lit_nolog_irq", irq_a, 0);
`endif
      tick();

      // saturation of the 4-bit counter, then clear together with an access
      for (int i = 0; i < 20; i++) begin
         drive(1, $urandom, 1'($urandom_range(0, 1)), IDW'($urandom_range(0, 31)));
         tick();
      end
`ifdef PER_ERROR_SLAVE_LOG_EN
      chk("lit_sat_cnt_b", cnt_b, 15);
`else
      chk("lit_sat_cnt_b", cnt_b, 0);
`endif
      i_log_clear = 1'b1;
      drive(1, 32'h0000_0100, 1, 9);
      tick();
      i_log_clear = 1'b0;
      drive(0, 0, 0, 0);
`ifdef PER_ERROR_SLAVE_LOG_EN
      chk("lit_clr_cnt_b", cnt_b, 1);
      chk("lit_clr_cnt_a", cnt_a, 1);
      chk("lit_clr_addr", eaddr_b, 32'h100);
      chk("lit_clr_irq", irq_b, 1);
`else
      chk("lit_clr_cnt_b", cnt_b, 0);
      chk("lit_clr_irq", irq_b, 0);
`endif
      tick(); tick(); tick(); tick();

      // reset with three responses in flight on the latency-4 instance
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h3000_0000, 1, IDW'(20 + i));
         tick();
      end
      drive(0, 0, 0, 0);
      i_rst_n = 1'b0;
      #1;
      chk("lit_rst_r_valid_b", bus_b.r_valid, 0);
      chk("lit_rst_irq_b", irq_b, 0);
      chk("lit_rst_cnt_b", cnt_b, 0);
      chk("lit_rst_addr_b", eaddr_b, 0);
      tick(); tick();
      i_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("lit_post_rst_r_valid_b", bus_b.r_valid, 0);
         chk("lit_post_rst_r_valid_a", bus_a.r_valid, 0);
      end

      // randomized traffic with occasional clears and one mid-run reset
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 1)),
               IDW'($urandom_range(0, 31)));
         i_log_clear = ($urandom_range(0, 99) < 4);
         if (c == 200) i_rst_n = 1'b0;
         if (c == 203) i_rst_n = 1'b1;
         tick();
      end
      drive(0, 0, 0, 0);
      i_log_clear = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
